// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the request fault check used at accept time.
package lsu_mem_ctrl_pkg;

  localparam int unsigned DEPTH_DEFAULT = 1024;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WRITE  = 2'b10,
    RESP   = 2'b11
  } lsu_state_e;

  // Misalignment, illegal funct3 (stores only allow B/H/W) and out-of-range word index.
  function automatic logic req_fault(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr, input int unsigned depth);
    logic f;
    f = 1'b0;
    case (f3)
      F3_B:    f = 1'b0;
      F3_H:    f = addr[0];
      F3_W:    f = |addr[1:0];
      F3_BU:   f = we;
      F3_HU:   f = we | addr[0];
      default: f = 1'b1;
    endcase
    if ({2'b00, addr[31:2]} >= 32'(depth)) f = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Lane steering: little-endian extraction/extension for loads and
// byte/halfword merge into the old word for read-modify-write stores.
module lsu_mem_ctrl_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [31:0] load_word,
  input  logic [31:0] store_old,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_ext,
  output logic [31:0] store_merged
);

  logic [31:0] shifted;

  always_comb begin
    shifted = load_word >> {off, 3'b000};
    case (funct3)
      F3_B:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_ext = {24'h000000, shifted[7:0]};
      F3_H:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_ext = {16'h0000, shifted[15:0]};
      default: load_ext = load_word;
    endcase
  end

  always_comb begin
    store_merged = store_old;
    case (funct3)
      F3_B:    store_merged[{off, 3'b000} +: 8] = wdata[7:0];
      F3_H:    store_merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_merged = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between EX/MEM and the word-addressed data memory.
// Holds the access FSM plus the latched request and response registers.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_fault,
  output logic [31:0] load_data,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  // Handshake: a request transfers on a cycle with req_valid && req_ready; req_ready is
  // high only in IDLE, and upstream keeps the request stable until it transfers.
  // resp_valid pulses for one cycle per transfer; resp_fault qualifies it.

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, wdata_q, merge_q;
  logic [2:0]  f3_q;
  logic        we_q, fault_q;
  logic        accept, req_flt, mem_we_raw;
  logic [31:0] load_ext, store_merged;

  assign accept  = req_valid && req_ready;
  assign req_flt = req_fault(req_we, req_funct3, req_addr, DEPTH);

  lsu_mem_ctrl_align u_align (
    .load_word    (mem_rd),
    .store_old    (merge_q),
    .wdata        (wdata_q),
    .off          (addr_q[1:0]),
    .funct3       (f3_q),
    .load_ext     (load_ext),
    .store_merged (store_merged)
  );

  always_comb begin
    state_d    = state_q;
    mem_a      = 32'h0;
    mem_wd     = 32'h0;
    mem_we_raw = 1'b0;
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_fault = (state_q == RESP) && fault_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = req_flt ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_a = {2'b00, addr_q[31:2]};
        if (!we_q) begin
          state_d = RESP;
        end else if (f3_q == F3_W) begin
          mem_we_raw = 1'b1;
          mem_wd     = wdata_q;
          state_d    = RESP;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        mem_a      = {2'b00, addr_q[31:2]};
        mem_we_raw = 1'b1;
        mem_wd     = store_merged;
        state_d    = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gate with reset so an operation abandoned by reset never lands a write.
  assign mem_we = mem_we_raw && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      merge_q   <= 32'h0;
      f3_q      <= 3'b000;
      we_q      <= 1'b0;
      fault_q   <= 1'b0;
      load_data <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        f3_q    <= req_funct3;
        we_q    <= req_we;
        fault_q <= req_flt;
      end
      if (state_q == ACCESS && !we_q) load_data <= load_ext;
      if (state_q == ACCESS && we_q)  merge_q   <= mem_rd;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: vector table of single requests plus
// hand-written reset-abort and back-to-back sequences against a memory model.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] load_data, mem_a, mem_wd, mem_rd;
  logic        mem_we;

  logic [31:0] mem [0:1023];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_load;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.DEPTH(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_fault(resp_fault), .load_data(load_data),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  assign mem_rd = (mem_a < 32'd1024) ? mem[mem_a[9:0]] : 32'h0;
  always @(posedge clk) if (mem_we) mem[mem_a[9:0]] <= mem_wd;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_fault;
    logic [3:0]  exp_lat;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [0:NV-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat, we_cnt;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    drive(v.we, v.f3, v.addr, v.wdata);
    check({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    we_cnt = 0;
    while (!resp_valid && lat < 10) begin
      if (mem_we) we_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (mem_we) we_cnt++;
    check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, "_fault"}, {31'h0, resp_fault}, {31'h0, v.exp_fault});
    check({tag, "_we_cycles"}, 32'(we_cnt), (v.we && !v.exp_fault) ? 32'd1 : 32'd0);
    if (!v.we && !v.exp_fault) last_load = v.exp_data;
    check({tag, "_load_data"}, load_data, last_load);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 3'b010, 32'h0,    32'h0,        32'h0000000A, 1'b0, 4'd2};
    vecs[1]  = '{1'b1, 3'b010, 32'h4,    32'h80FF7F01, 32'h0,        1'b0, 4'd2};
    vecs[2]  = '{1'b0, 3'b000, 32'h4,    32'h0,        32'h00000001, 1'b0, 4'd2};
    vecs[3]  = '{1'b0, 3'b000, 32'h5,    32'h0,        32'h0000007F, 1'b0, 4'd2};
    vecs[4]  = '{1'b0, 3'b000, 32'h6,    32'h0,        32'hFFFFFFFF, 1'b0, 4'd2};
    vecs[5]  = '{1'b0, 3'b100, 32'h6,    32'h0,        32'h000000FF, 1'b0, 4'd2};
    vecs[6]  = '{1'b0, 3'b001, 32'h6,    32'h0,        32'hFFFF80FF, 1'b0, 4'd2};
    vecs[7]  = '{1'b0, 3'b101, 32'h6,    32'h0,        32'h000080FF, 1'b0, 4'd2};
    vecs[8]  = '{1'b1, 3'b000, 32'h9,    32'h000000AB, 32'h0,        1'b0, 4'd3};
    vecs[9]  = '{1'b0, 3'b010, 32'h8,    32'h0,        32'h1122AB44, 1'b0, 4'd2};
    vecs[10] = '{1'b1, 3'b001, 32'h3,    32'h0000BEEF, 32'h0,        1'b1, 4'd1};
    vecs[11] = '{1'b0, 3'b010, 32'h1000, 32'h0,        32'h0,        1'b1, 4'd1};
    vecs[12] = '{1'b0, 3'b011, 32'h0,    32'h0,        32'h0,        1'b1, 4'd1};
    vecs[13] = '{1'b1, 3'b010, 32'h2,    32'h12345678, 32'h0,        1'b1, 4'd1};
    vecs[14] = '{1'b1, 3'b100, 32'h0,    32'h0,        32'h0,        1'b1, 4'd1};
    vecs[15] = '{1'b0, 3'b101, 32'h7,    32'h0,        32'h0,        1'b1, 4'd1};
    vecs[16] = '{1'b0, 3'b001, 32'h0FFE, 32'h0,        32'h0,        1'b0, 4'd2};

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0]    = 32'h0000000A;
    mem[2]    = 32'h11223344;
    mem[1023] = 32'h8001_0000;
    vecs[16].exp_data = 32'hFFFF8001;

    last_load  = 32'h0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", {31'h0, req_ready}, 32'h1);
    check("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("reset_resp_fault", {31'h0, resp_fault}, 32'h0);
    check("reset_load_data", load_data, 32'h0);
    check("reset_mem_we", {31'h0, mem_we}, 32'h0);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);
    check("sb_merge_word", mem[2], 32'h1122AB44);
    check("sw_word", mem[1], 32'h80FF7F01);

    // Reset lands while an SB sits in WRITE: the write must be dropped.
    @(negedge clk);
    drive(1'b1, 3'b000, 32'h8, 32'h000000CD);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rstwr_we_before_rst", {31'h0, mem_we}, 32'h1);
    rst = 1'b1;
    #1;
    check("rstwr_we_gated", {31'h0, mem_we}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    last_load = 32'h0;
    check("rstwr_word_kept", mem[2], 32'h1122AB44);
    @(negedge clk);
    check("rstwr_ready", {31'h0, req_ready}, 32'h1);
    check("rstwr_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rstwr_load_data", load_data, 32'h0);

    // Back-to-back requests with req_valid held high across them.
    begin
      int accepts, resps, guard;
      logic [2:0] fault_seen;
      logic [31:0] lw_data;
      logic rdy;
      accepts = 0;
      resps = 0;
      fault_seen = 3'b000;
      lw_data = 32'h0;
      fork
        begin
          for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            case (r)
              0: drive(1'b1, 3'b010, 32'hC, 32'h00000005);
              1: drive(1'b0, 3'b010, 32'hC, 32'h0);
              default: drive(1'b1, 3'b001, 32'hE, 32'h0000BEEF);
            endcase
            guard = 0;
            rdy = req_ready;
            while (!rdy && guard < 20) begin
              @(negedge clk);
              rdy = req_ready;
              guard++;
            end
            if (rdy) accepts++;
            @(posedge clk);
          end
          #1 req_valid = 1'b0;
        end
        begin
          repeat (30) begin
            @(negedge clk);
            if (resp_valid) begin
              if (resps < 3) fault_seen[resps] = resp_fault;
              if (resps == 1) lw_data = load_data;
              resps++;
            end
          end
        end
      join
      check("b2b_accepts", 32'(accepts), 32'd3);
      check("b2b_resps", 32'(resps), 32'd3);
      check("b2b_faults", {29'h0, fault_seen}, 32'h0);
      check("b2b_lw_data", lw_data, 32'h00000005);
      check("b2b_final_word", mem[3], 32'hBEEF0005);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
